// File: rtl/pmem_burst_responder.sv
// Memory-side responder for the 64-bit pmem burst interface: serves one 32-byte
// line as four back-to-back 64-bit beats after a fixed access latency.
module pmem_burst_responder #(
  parameter int LINES   = 256,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pmem_address,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [63:0] pmem_wdata,
  output logic [63:0] pmem_rdata,
  output logic        pmem_resp,
  output logic        busy,
  output logic        proto_err,
  output logic [2:0]  dbg_state
);

  localparam int IDX_W = $clog2(LINES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    RBURST = 3'd2,
    WBURST = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Handshake: a request (read or write) is held with a stable line address
  // until the fourth pmem_resp beat; the initiator then drops it, and the
  // responder returns to IDLE only after seeing both request lines low.

  state_t           state_q, state_d;
  logic [3:0]       lat_q, lat_d;
  logic [1:0]       beat_q, beat_d;
  logic             op_rd_q, op_rd_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [26:0]      tag_q, tag_d;
  logic             in_txn;
  logic             req_held;
  logic             err_now;
  logic             addr_unused;

  logic [255:0] mem [LINES];

  assign addr_unused = ^pmem_address[4:0];

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    op_rd_d = op_rd_q;
    idx_d   = idx_q;
    tag_d   = tag_q;
    case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          state_d = WAIT;
          lat_d   = 4'(LATENCY - 1);
          op_rd_d = pmem_read;
          idx_d   = pmem_address[5 +: IDX_W];
          tag_d   = pmem_address[31:5];
        end
      end
      WAIT: begin
        if (lat_q == 4'd0) begin
          state_d = op_rd_q ? RBURST : WBURST;
          beat_d  = 2'd0;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RBURST, WBURST: begin
        if (beat_q == 2'd3) state_d = DONE;
        else                beat_d  = beat_q + 2'd1;
      end
      DONE: begin
        if (!pmem_read && !pmem_write) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Violations are only observed; the transaction always finishes as latched.
  always_comb begin
    in_txn   = (state_q == WAIT) || (state_q == RBURST) || (state_q == WBURST);
    req_held = op_rd_q ? pmem_read : pmem_write;
    err_now  = (pmem_read && pmem_write) ||
               (in_txn && (!req_held || (pmem_address[31:5] != tag_q)));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      lat_q      <= 4'd0;
      beat_q     <= 2'd0;
      op_rd_q    <= 1'b0;
      idx_q      <= '0;
      tag_q      <= '0;
      pmem_rdata <= '0;
      pmem_resp  <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      beat_q     <= beat_d;
      op_rd_q    <= op_rd_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      pmem_resp  <= (state_d == RBURST) || (state_d == WBURST);
      pmem_rdata <= (state_d == RBURST) ? mem[idx_d][{beat_d, 6'd0} +: 64] : '0;
      proto_err  <= proto_err | err_now;
    end
  end

  // Storage is never cleared; a reset edge simply suppresses the pending beat.
  always_ff @(posedge clk) begin
    if (rst && (state_q == WBURST)) begin
      mem[idx_q][{beat_q, 6'd0} +: 64] <= pmem_wdata;
    end
  end

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Scoreboard bench for pmem_burst_responder: read beats are queued from a line
// model when the request is driven and popped as the responder strobes them.
module tb_pmem_burst_responder;

  localparam int LINES = 256;
  localparam int LAT   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pmem_address;
  logic        pmem_read;
  logic        pmem_write;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;
  logic        busy;
  logic        proto_err;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0]  exp_q[$];
  logic [255:0] model_mem [int];

  pmem_burst_responder #(.LINES(LINES), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .busy         (busy),
    .proto_err    (proto_err),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 5) % LINES);
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // One full transaction starting from IDLE; cycle 0 is the request cycle.
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic rd,
                         input logic wr, input logic [255:0] wline, input int hold);
    logic [31:0]  resp_seen, resp_exp, busy_seen, busy_exp;
    logic [255:0] ln;
    int b;
    int last;
    last      = LAT + 4 + hold;
    resp_seen = '0; resp_exp = '0; busy_seen = '0; busy_exp = '0;
    b = 0;
    if (rd) begin
      ln = model_mem[idx_of(addr)];
      for (int i = 0; i < 4; i++) exp_q.push_back(ln[64*i +: 64]);
    end
    @(posedge clk); #1;
    pmem_address = addr;
    pmem_read    = rd;
    pmem_write   = wr;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      resp_seen[c] = pmem_resp;
      busy_seen[c] = busy;
      resp_exp[c]  = (c >= LAT + 1) && (c <= LAT + 4);
      busy_exp[c]  = (c >= 1);
      if (pmem_resp) begin
        if (rd) begin
          if (exp_q.size() == 0) check({tag, "_extra_beat"}, 64'd1, 64'd0);
          else check({tag, "_rdata"}, pmem_rdata, exp_q.pop_front());
        end else if (b < 4) begin
          pmem_wdata = wline[64*b +: 64];
        end
        b++;
      end
    end
    check({tag, "_resp_pattern"}, 64'(resp_seen), 64'(resp_exp));
    check({tag, "_busy_pattern"}, 64'(busy_seen), 64'(busy_exp));
    check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    if (wr && !rd) model_mem[idx_of(addr)] = wline;
    @(posedge clk); #1;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_wdata = '0;
    @(negedge clk);
    check({tag, "_busy_release_cycle"}, 64'(busy), 64'd1);
    check({tag, "_rdata_idle"}, pmem_rdata, 64'd0);
    @(negedge clk);
    check({tag, "_busy_after_release"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [255:0] line_a, line_b, line_c, line_d;
    logic [31:0]  ra;
    int b;
    logic hit;

    rst = 1'b0; pmem_address = '0; pmem_read = 1'b0; pmem_write = 1'b0; pmem_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_resp", 64'(pmem_resp), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_proto_err", 64'(proto_err), 64'd0);
    check("reset_rdata", pmem_rdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_txn("wr_100", 32'h0000_0100, 1'b0, 1'b1, line_a, 0);
    run_txn("rd_100", 32'h0000_0100, 1'b1, 1'b0, '0, 0);
    check("basic_proto_err", 64'(proto_err), 64'd0);

    line_b = rand_line();
    run_txn("wr_040", 32'h0000_0040, 1'b0, 1'b1, line_b, 0);
    run_txn("rd_2040_alias", 32'h0000_2040, 1'b1, 1'b0, '0, 0);
    run_txn("rd_047_lowbits", 32'h0000_0047, 1'b1, 1'b0, '0, 0);

    run_txn("rd_hold", 32'h0000_0100, 1'b1, 1'b0, '0, 3);
    run_txn("rd_after_hold", 32'h0000_0040, 1'b1, 1'b0, '0, 0);

    for (int i = 0; i < 4; i++) begin
      ra = {$urandom_range(0, 255), 5'(i), 5'($urandom_range(0, 31))} & 32'hFFFF_FFFF;
      run_txn("wr_rand", ra, 1'b0, 1'b1, rand_line(), 0);
      run_txn("rd_rand", ra ^ 32'h0000_001F, 1'b1, 1'b0, '0, 0);
    end
    check("random_proto_err", 64'(proto_err), 64'd0);

    run_txn("rd_both", 32'h0000_0100, 1'b1, 1'b1, '0, 0);
    check("both_proto_err", 64'(proto_err), 64'd1);
    run_txn("rd_after_both", 32'h0000_0040, 1'b1, 1'b0, '0, 0);
    check("sticky_proto_err", 64'(proto_err), 64'd1);

    line_c = rand_line();
    line_d = rand_line();
    run_txn("wr_300_old", 32'h0000_0300, 1'b0, 1'b1, line_c, 0);
    @(posedge clk); #1;
    pmem_address = 32'h0000_0300;
    pmem_write   = 1'b1;
    b   = 0;
    hit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pmem_resp) begin
        if (b == 2) begin
          rst        = 1'b0;
          pmem_write = 1'b0;
          hit        = 1'b1;
          break;
        end
        pmem_wdata = line_d[64*b +: 64];
        b++;
      end
    end
    check("reset_reached_beat2", 64'(hit), 64'd1);
    @(negedge clk);
    check("midreset_resp", 64'(pmem_resp), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_proto_err", 64'(proto_err), 64'd0);
    @(posedge clk); #1;
    rst        = 1'b1;
    pmem_wdata = '0;
    model_mem[idx_of(32'h0000_0300)] = {line_c[255:128], line_d[127:0]};
    run_txn("rd_300_partial", 32'h0000_0300, 1'b1, 1'b0, '0, 0);
    check("final_proto_err", 64'(proto_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
